expander_arbiter: RTL
=====================

Name: expander_arbiter

Overview:
- Shares one bus_expander between NUM_REQ requesters, e.g. the MCU core and the debugger.
- Each requester issues single-word read or write transactions through a req/ack handshake.
- The block drives the expander protocol: load the address register, then write the data register once, or read it twice and capture the second value.
- Grants are round-robin. A transaction is atomic once granted, so no requester can break another's expander access.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).

Ports:
- sysclk  in  1  system clock.
- sysreset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester transaction request; held until ack.
- we  in  NUM_REQ  per-requester write flag (1=write, 0=read); stable while req high.
- addr  in  16*NUM_REQ  per-requester expander register address, slice i = bits 16i+15:16i; stable while req high.
- wdata  in  16*NUM_REQ  per-requester write data, same slicing; stable while req high.
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rdata  out  16  read result; valid in the ack cycle and held until the next read completes.
- grant  out  NUM_REQ  one-hot owner of the current transaction; 0 when idle.
- hold  in  1  blocks new grants (debugger break); never aborts an in-flight transaction.
- busy  out  1  high whenever state != IDLE.
- exp_data_in  out  16  to expander data_in.
- exp_address_load  out  1  to expander address_load.
- exp_data_load  out  1  to expander data_load.
- exp_data_read  out  1  to expander data_read.
- exp_data_out  in  16  from expander data_out.

Behaviour:
- Reset (sysclk edge with sysreset high), including mid-transaction:
  - state=IDLE; grant, ack, rdata and busy = 0; all exp_* strobes = 0; exp_data_in = 0.
  - last-grant pointer = NUM_REQ-1, so requester 0 wins first.
- States: IDLE, ADDR, WR, WR_WAIT, RD1, RD2, RD_CAP, DONE.
- IDLE:
  - If hold=0 and req != 0, pick the first requesting index after the last-grant pointer, cyclically.
  - Register grant (one-hot), the granted index, and that requester's we, addr and wdata.
  - Update the pointer, then go to ADDR. Otherwise stay in IDLE.
- ADDR: exp_address_load=1, exp_data_in=latched addr. Next state WR if we=1, else RD1.
- WR: exp_data_load=1, exp_data_in=latched wdata. Next WR_WAIT.
- WR_WAIT: all strobes low; the expander fires r_load in this cycle. Next DONE.
- RD1: exp_data_read=1. This is the throwaway read. Next RD2.
- RD2: exp_data_read=1. The expander fires r_read in this cycle. Next RD_CAP.
- RD_CAP: on the edge ending this state, rdata <= exp_data_out. Next DONE.
- DONE: ack[granted]=1 for exactly this cycle, grant still asserted. Next IDLE, where grant clears.
- Strobes are registered outputs. exp_data_in is 0 whenever no strobe is active. At most one exp_* strobe is high in any cycle.
- Requester rule: in the cycle after ack, deassert req or present a new transaction. The arbiter ignores req during every non-IDLE state.
- Latency from req first seen in IDLE at T0:
  - Write: ack at T4.
  - Read: ack at T5.
  - Minimum spacing between transactions is 5 cycles (write) or 6 cycles (read).
- Simultaneous requests: round-robin means no requester is granted twice while another has been waiting since before the earlier grant.
- If req drops mid-transaction, the transaction still completes and ack still pulses; the requester has violated the protocol.
- hold rising during a transaction: that transaction finishes; the next grant waits until hold=0.
- Read-sensitive slaves see exactly one r_read per read and exactly one r_load per write.

Test Plan:
- Write: requester 0 writes addr=0x0005, wdata=0xBEEF. Required: exp_address_load with 0x0005 at T1, exp_data_load with 0xBEEF at T2, ack[0] at T4, model slave 5 holds 0xBEEF.
- Read: slave 3 holds 0x1234; requester 1 reads addr=3. Required: exp_data_read high at T2 and T3 only, slave sees one r_read, ack[1] at T5 with rdata=0x1234.
- Contention: req=2'b11 held continuously after reset, 4 transactions. Required: grant order 0,1,0,1 with no overlapping strobes.
- Hold: hold asserted in RD1 of requester 0 while requester 1 is pending. Required: requester 0 acks normally; requester 1 is not granted until 1 cycle after hold falls.
- Reset mid-write: sysreset pulses during WR. Required: next cycle state IDLE, all outputs 0; the following request is granted to requester 0.
- Back-to-back: requester 0 presents a new read in the cycle after ack. Required: granted in IDLE, ack 6 cycles after the prior ack.

Source files
------------

// File: rtl/expander_arbiter.sv
// expander_arbiter: round-robin arbiter sharing one bus_expander between NUM_REQ requesters
module expander_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                   sysclk,
  input  logic                   sysreset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     we,
  input  logic [16*NUM_REQ-1:0]  addr,
  input  logic [16*NUM_REQ-1:0]  wdata,
  output logic [NUM_REQ-1:0]     ack,
  output logic [15:0]            rdata,
  output logic [NUM_REQ-1:0]     grant,
  input  logic                   hold,
  output logic                   busy,
  output logic [15:0]            exp_data_in,
  output logic                   exp_address_load,
  output logic                   exp_data_load,
  output logic                   exp_data_read,
  input  logic [15:0]            exp_data_out
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [2:0] {IDLE, ADDR, WR, WR_WAIT, RD1, RD2, RD_CAP, DONE} state_t;
  state_t r_state, w_next;
  logic [IW-1:0]      r_ptr, w_pick, w_c;
  logic [NUM_REQ-1:0] r_grant, r_ack, w_onehot;
  logic               r_we, r_al, r_dl, r_dr;
  logic [15:0]        r_wdata, r_din, r_rdata, w_sel_addr;
  // scan from farthest to nearest so the first requester after r_ptr wins
  always_comb begin
    w_pick = r_ptr;
    w_c = '0;
    for (int j = NUM_REQ; j >= 1; j--) begin
      w_c = IW'((int'(r_ptr) + j) % NUM_REQ);
      if (req[w_c]) w_pick = w_c;
    end
  end
  assign w_onehot   = NUM_REQ'(1) << w_pick;
  assign w_sel_addr = addr[{w_pick, 4'b0} +: 16];
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (!hold && |req) ? ADDR : IDLE;
      ADDR:    w_next = r_we ? WR : RD1;
      WR:      w_next = WR_WAIT;
      WR_WAIT: w_next = DONE;
      RD1:     w_next = RD2;
      RD2:     w_next = RD_CAP;
      RD_CAP:  w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  // strobes are decoded from the next state so they line up with the state cycle
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      r_state <= IDLE;
      r_ptr   <= IW'(NUM_REQ - 1);
      r_grant <= '0;
      r_ack   <= '0;
      r_rdata <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_al    <= 1'b0;
      r_dl    <= 1'b0;
      r_dr    <= 1'b0;
      r_din   <= '0;
    end else begin
      r_state <= w_next;
      r_al    <= w_next == ADDR;
      r_dl    <= w_next == WR;
      r_dr    <= w_next == RD1 || w_next == RD2;
      r_din   <= w_next == ADDR ? w_sel_addr : w_next == WR ? r_wdata : '0;
      r_ack   <= w_next == DONE ? r_grant : '0;
      if (r_state == RD_CAP) r_rdata <= exp_data_out;
      if (w_next == ADDR) begin
        r_grant <= w_onehot;
        r_ptr   <= w_pick;
        r_we    <= we[w_pick];
        r_wdata <= wdata[{w_pick, 4'b0} +: 16];
      end else if (w_next == IDLE) r_grant <= '0;
    end
  end
  assign ack              = r_ack;
  assign rdata            = r_rdata;
  assign grant            = r_grant;
  assign busy             = r_state != IDLE;
  assign exp_data_in      = r_din;
  assign exp_address_load = r_al;
  assign exp_data_load    = r_dl;
  assign exp_data_read    = r_dr;
endmodule
